// File: rtl/sra_unit.sv
// sra_unit: two-stage pipelined 16-bit arithmetic-shift-right unit.
//
// Handshake: in_valid qualifies A/B/shamt/var_sel on the rising edge where it
// is sampled high. Exactly two edges later out_valid is high for one cycle
// with out/zero holding that result. There is no ready and no stall, so every
// accepted input produces exactly one output. While out_valid is low, out and
// zero keep the most recent result.
//
// The shift amount is split across the two stages. Stage 1 shifts by
// amt[1:0], which is 0..3. Stage 2 shifts by 4*amt[3:2], which is 0, 4, 8 or
// 12. Both shifts are arithmetic. Stage 1 therefore leaves A[15] in
// s1_data[15], and stage 2 fills with the original sign bit.
module sra_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             var_sel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             zero
);

    localparam int HW = SHW - 2;  // width of the coarse (multiple-of-4) amount

    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] s1_next;
    logic [WIDTH-1:0] s1_data;
    logic [HW-1:0]    s1_amt_hi;
    logic             s1_valid;
    logic [WIDTH-1:0] s2_next;

    // B only supplies the amount. Its upper bits are collected here on purpose.
    logic unused_b_hi;
    assign unused_b_hi = ^B[WIDTH-1:SHW];

    // Select the amount and do the fine shift (0..3) ahead of stage 1.
    always_comb begin
        amt     = var_sel ? B[SHW-1:0] : shamt;
        s1_next = $signed(A) >>> amt[1:0];
    end

    // Stage 1: the valid bit always updates; the data loads only on a valid input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_amt_hi <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data   <= s1_next;
                s1_amt_hi <= amt[SHW-1:2];
            end
        end
    end

    // Coarse shift by 4*s1_amt_hi. s1_data[15] already equals the original A[15].
    always_comb begin
        s2_next = $signed(s1_data) >>> {s1_amt_hi, 2'b00};
    end

    // Stage 2: register the result and its zero flag; both hold when no valid arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            zero      <= 1'b1;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out  <= s2_next;
                zero <= (s2_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_sra_unit.sv
// tb_sra_unit: directed vectors with hand-computed results; the expected
// {zero, out} values go through a queue and a monitor checks them.
module tb_sra_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         var_sel = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [3:0]   shamt = '0;
    logic [W-1:0] out;
    logic         out_valid;
    logic         zero;

    logic [W:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    sra_unit #(.WIDTH(W), .SHW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .var_sel(var_sel),
        .A(A), .B(B), .shamt(shamt),
        .out(out), .out_valid(out_valid), .zero(zero)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Drive one input. If push is set, record the expected result; it is not
    // set for an input that a reset is meant to discard.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] sh,
                         input logic vs, input logic [W-1:0] exp, input logic push);
        @(negedge clk);
        A = a; B = b; shamt = sh; var_sel = vs; in_valid = 1'b1;
        if (push) exp_q.push_back({(exp == '0), exp});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            A = W'($urandom);
            B = W'($urandom);
            shamt = 4'($urandom_range(0, 15));
        end
    endtask

    // Monitor: every out_valid must match the oldest expected entry.
    always @(negedge clk) begin
        logic [W:0] e;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out_valid: got out=%h, required no output", out);
            end else begin
                e = exp_q.pop_front();
                check("result{zero,out}", 32'({zero, out}), 32'(e));
            end
        end
    end

    initial begin
        // Reset held with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            var_sel = 1'($urandom_range(0, 1));
            A = W'($urandom);
            B = W'($urandom);
            shamt = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        check("reset_out", 32'(out), 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_zero", 32'(zero), 32'h1);
        in_valid = 1'b0;
        rst_n = 1'b1;
        idle(2);

        // Immediate form. Each B differs from shamt to show that B is unused here.
        issue(16'h0002, 16'h000F, 4'd1,  1'b0, 16'h0001, 1'b1);
        issue(16'h8000, 16'h0000, 4'd4,  1'b0, 16'hF800, 1'b1);
        issue(16'h8000, 16'h0001, 4'd15, 1'b0, 16'hFFFF, 1'b1);
        issue(16'h7FFF, 16'h0000, 4'd15, 1'b0, 16'h0000, 1'b1);
        issue(16'hFFFF, 16'h0000, 4'd7,  1'b0, 16'hFFFF, 1'b1);
        issue(16'h0000, 16'h0001, 4'd3,  1'b0, 16'h0000, 1'b1);
        issue(16'hC350, 16'h0002, 4'd5,  1'b0, 16'hFE1A, 1'b1);
        // Variable form: the amount comes from B[3:0]; shamt and B[15:4] are ignored.
        issue(16'h7FF0, 16'h0013, 4'd0,  1'b1, 16'h0FFE, 1'b1);
        issue(16'h7FF0, 16'hFFF3, 4'd5,  1'b1, 16'h0FFE, 1'b1);
        issue(16'h8001, 16'h0008, 4'd1,  1'b1, 16'hFF80, 1'b1);
        issue(16'h1234, 16'hABC0, 4'd9,  1'b1, 16'h1234, 1'b1);
        idle(4);

        // Back-to-back pipeline, then out must hold after in_valid drops.
        issue(16'h0002, 16'h0000, 4'd1, 1'b0, 16'h0001, 1'b1);
        issue(16'hFFF0, 16'h0000, 4'd2, 1'b0, 16'hFFFC, 1'b1);
        issue(16'h1234, 16'h0000, 4'd0, 1'b0, 16'h1234, 1'b1);
        idle(4);
        check("hold_out", 32'(out), 32'h1234);
        check("hold_out_valid", 32'(out_valid), 32'h0);
        check("hold_zero", 32'(zero), 32'h0);

        // Asynchronous reset between clock edges must clear out immediately.
        issue(16'h0400, 16'h0000, 4'd2, 1'b0, 16'h0100, 1'b1);
        idle(4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(out), 32'h0);
        check("async_rst_out_valid", 32'(out_valid), 32'h0);
        check("async_rst_zero", 32'(zero), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Reset in mid-flight: the in-flight input must never reach out_valid.
        issue(16'h4000, 16'h0000, 4'd2, 1'b0, 16'h1000, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(4);
        check("midflight_out", 32'(out), 32'h0);
        check("midflight_zero", 32'(zero), 32'h1);

        // Operation after the reset needs a new input.
        issue(16'hC350, 16'h0000, 4'd5, 1'b0, 16'hFE1A, 1'b1);
        idle(1);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sra_unit.md
Name: sra_unit

Overview:
- 16-bit arithmetic-shift-right execution unit for the CPU datapath ALU.
- Shifts operand A right by a 4-bit amount and fills vacated MSBs with A[15] (sign).
- Shift amount comes from the instruction field shamt (immediate form) or from B[3:0] (variable form).
- Two-stage pipelined barrel shifter, one result per clock, with valid tracking and a zero flag.

Parameters:
- WIDTH, 16, data width of A, B and out. Spec values assume 16.
- SHW, 4, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- var_sel  input  1  0: amount = shamt; 1: amount = B[SHW-1:0]
- A  input  WIDTH  operand to be shifted, two's complement
- B  input  WIDTH  variable shift-amount source; bits above SHW-1 ignored
- shamt  input  SHW  immediate shift amount
- out  output  WIDTH  registered result, A >>> amount
- out_valid  output  1  out holds a new result this cycle
- zero  output  1  1 when out == 0

Behaviour:
- Reset (rst_n low, asynchronous, overrides all):
  - all pipeline registers clear.
  - out = 0, out_valid = 0, zero = 1.
  - stage-1 valid = 0.
- Amount selection happens combinationally at input: amt = var_sel ? B[3:0] : shamt.
- Stage 1 (first rising edge):
  - registers s1_data = A >>> amt[1:0] (shift by 0..3, sign fill).
  - registers s1_amt_hi = amt[3:2].
  - registers s1_valid = in_valid.
- Stage 2 (second rising edge):
  - out = s1_data >>> (4*s1_amt_hi) (shift by 0, 4, 8 or 12, sign fill).
  - out_valid = s1_valid.
  - zero = (next out == 0).
- Latency and throughput:
  - latency exactly 2 cycles from in_valid sampled to out_valid high.
  - fully pipelined; back-to-back inputs give back-to-back outputs.
  - no stall or backpressure.
- Hold behaviour:
  - stage registers load only when their incoming valid is 1.
  - otherwise data registers hold their value; the valid bits still update, so out_valid drops to 0.
  - out and zero therefore retain the last result when out_valid = 0.
- Arithmetic rules:
  - result equals signed A shifted right by amt, i.e. floor(A / 2^amt).
  - amt = 0 passes A unchanged.
  - amt = 15 yields 0xFFFF for negative A and 0x0000 for non-negative A.
  - shift amounts of 16 or more are not representable; the B[15:4] bits never affect the result.
- Sign bit:
  - taken from the original A[15].
  - the stage-1 result must preserve it; stage 2 fills from s1_data[15], which equals A[15].
- B is used only as the amount source; B is never shifted.
- Reset asserted mid-operation discards all in-flight results; the first valid output after rst_n rises requires a new in_valid.

Test Plan:
- Reset: hold rst_n = 0 with random inputs -> out = 0x0000, out_valid = 0, zero = 1; assert reset asynchronously between edges -> outputs clear immediately.
- Immediate, positive A: A = 0x0002, B = 0x0000, shamt = 1, var_sel = 0, in_valid pulse -> two cycles later out = 0x0001, out_valid = 1, zero = 0.
- Sign fill: A = 0x8000 with shamt = 4 -> out = 0xF800; with shamt = 15 -> out = 0xFFFF; A = 0x7FFF, shamt = 15 -> out = 0x0000, zero = 1.
- Variable mode: var_sel = 1, B = 0x0013 (amt 3), A = 0x7FF0, shamt = 0 -> out = 0x0FFE; upper bits of B have no effect.
- Pipelining: drive three consecutive valid inputs (0x0002/1, 0xFFF0/2, 0x1234/0) -> outputs 0x0001, 0xFFFC, 0x1234 on three consecutive cycles; when in_valid goes low, out_valid = 0 and out holds 0x1234.
- Reset mid-flight: issue a valid input, assert rst_n = 0 one cycle later -> no out_valid pulse appears; out = 0 after reset.
